// File: rtl/hex_display_scheduler.sv
// Round-robin owner of a shared HEX1:HEX0 display pair; blanks the pair when nobody holds it.
// Optional build macro HEX_SCHED_PRIO_EN: requester 0 preempts any other owner.
module hex_display_scheduler #(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic [3:0]         digit_hi,
    output logic [3:0]         digit_lo,
    output logic               blank
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0]    PTR_RESET  = PW'(N_REQ - 1);
    localparam logic [CW-1:0]    COUNT_LOAD = CW'(DWELL - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);
    localparam logic [3:0]       BLANK_CODE = 4'hF;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;

    logic [7:0]    slice [N_REQ];
    logic [PW-1:0] win;
    logic          found;
    int            arb_idx;
    logic          any_req;
    logic          owner_req;
    logic          expired;
    logic          rel_now;
    logic          preempt;
    logic          grant_now;
    logic [PW-1:0] grant_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = data[8*i +: 8];
        end
    end

    // Search starts just past the last winner and wraps, so the previous owner is checked last.
    always_comb begin
        found   = 1'b0;
        win     = ptr;
        arb_idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = int'(ptr) + k;
            if (arb_idx >= N_REQ) begin
                arb_idx = arb_idx - N_REQ;
            end
            if (!found && req[PW'(arb_idx)]) begin
                found = 1'b1;
                win   = PW'(arb_idx);
            end
        end
    end

    assign any_req   = |req;
    assign owner_req = req[ptr];
    assign expired   = (count == '0);
    assign rel_now   = expired || !owner_req;

`ifdef HEX_SCHED_PRIO_EN
    assign preempt = req[0] && (ptr != '0);
`else
    assign preempt = 1'b0;
`endif

    // While owning, ptr always names the current owner, so it doubles as the owner index.
    always_comb begin
        grant_now = 1'b0;
        grant_idx = win;
        if (state == IDLE) begin
            grant_now = any_req;
        end else if (preempt) begin
            grant_now = 1'b1;
            grant_idx = '0;
        end else begin
            grant_now = rel_now && any_req;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            digit_hi <= BLANK_CODE;
            digit_lo <= BLANK_CODE;
            blank    <= 1'b1;
            count    <= '0;
            ptr      <= PTR_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state    <= OWN;
                        gnt      <= ONE_HOT0 << grant_idx;
                        ptr      <= grant_idx;
                        count    <= COUNT_LOAD;
                        digit_hi <= slice[grant_idx][7:4];
                        digit_lo <= slice[grant_idx][3:0];
                        blank    <= 1'b0;
                    end else begin
                        gnt      <= '0;
                        digit_hi <= BLANK_CODE;
                        digit_lo <= BLANK_CODE;
                        blank    <= 1'b1;
                    end
                end
                OWN: begin
                    if (grant_now) begin
                        gnt      <= ONE_HOT0 << grant_idx;
                        ptr      <= grant_idx;
                        count    <= COUNT_LOAD;
                        digit_hi <= slice[grant_idx][7:4];
                        digit_lo <= slice[grant_idx][3:0];
                        blank    <= 1'b0;
                    end else if (rel_now) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        count    <= '0;
                        digit_hi <= BLANK_CODE;
                        digit_lo <= BLANK_CODE;
                        blank    <= 1'b1;
                    end else begin
                        count    <= count - 1'b1;
                        digit_hi <= slice[ptr][7:4];
                        digit_lo <= slice[ptr][3:0];
                        blank    <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    digit_hi <= BLANK_CODE;
                    digit_lo <= BLANK_CODE;
                    blank    <= 1'b1;
                    count    <= '0;
                    ptr      <= PTR_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with N_REQ=4, DWELL=4; expectations hand-computed per scenario.
module tb_hex_display_scheduler;

    logic        CLOCK_50;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  digit_hi;
    logic [3:0]  digit_lo;
    logic        blank;
    logic [12:0] obs;

    int check_count;
    int pass_count;

    hex_display_scheduler #(
        .N_REQ(4),
        .DWELL(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .req(req),
        .data(data),
        .gnt(gnt),
        .digit_hi(digit_hi),
        .digit_lo(digit_lo),
        .blank(blank)
    );

    assign obs = {gnt, digit_hi, digit_lo, blank};

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Outputs are sampled and inputs changed 1 ns after each rising edge.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        exp_v = {4'b0000, 4'hF, 4'hF, 1'b1};
        reset = 1'b1;
        req   = '0;
        data  = 32'h12345678;
        step();
        check_count++;
        if (obs !== exp_v)
            $display("[TB] FAIL reset_held: got gnt=%b hi=%h lo=%h blank=%b want gnt=%b hi=%h lo=%h blank=%b",
                     gnt, digit_hi, digit_lo, blank, exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
        else pass_count++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_count++;
            if (obs !== exp_v)
                $display("[TB] FAIL idle[%0d]: got gnt=%b hi=%h lo=%h blank=%b want gnt=%b hi=%h lo=%h blank=%b",
                         i, gnt, digit_hi, digit_lo, blank, exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            else pass_count++;
        end
    endtask

    // Sole requester keeps the display across dwell boundaries with no blank cycle.
    task automatic test_single();
        logic [12:0] exp_v;
        do_reset();
        data       = '0;
        data[7:0]  = 8'h42;
        req        = 4'b0001;
        exp_v      = {4'b0001, 4'h4, 4'h2, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step();
            check_count++;
            if (obs !== exp_v)
                $display("[TB] FAIL single[%0d]: got gnt=%b hi=%h lo=%h blank=%b want gnt=%b hi=%h lo=%h blank=%b",
                         i, gnt, digit_hi, digit_lo, blank, exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            else pass_count++;
        end
    endtask

    task automatic test_live_digits();
        do_reset();
        data      = '0;
        data[7:0] = 8'h42;
        req       = 4'b0001;
        step();
        data[7:0] = 8'hAB;
        #1;
        check_count++;
        if (obs !== {4'b0001, 4'h4, 4'h2, 1'b0})
            $display("[TB] FAIL live_before_edge: got gnt=%b hi=%h lo=%h want gnt=0001 hi=4 lo=2", gnt, digit_hi, digit_lo);
        else pass_count++;
        step();
        check_count++;
        if (obs !== {4'b0001, 4'hA, 4'hB, 1'b0})
            $display("[TB] FAIL live_after_edge: got gnt=%b hi=%h lo=%h blank=%b want gnt=0001 hi=a lo=b blank=0",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
    endtask

    task automatic test_round_robin();
        logic [12:0] exp_v;
        do_reset();
        data        = '0;
        data[15:8]  = 8'h17;
        data[31:24] = 8'h93;
        req         = 4'b1010;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_v = (i < 4 || i == 8) ? {4'b0010, 4'h1, 4'h7, 1'b0} : {4'b1000, 4'h9, 4'h3, 1'b0};
            check_count++;
            if (obs !== exp_v)
                $display("[TB] FAIL round_robin[%0d]: got gnt=%b hi=%h lo=%h blank=%b want gnt=%b hi=%h lo=%h blank=%b",
                         i, gnt, digit_hi, digit_lo, blank, exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            else pass_count++;
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        data        = '0;
        data[15:8]  = 8'h17;
        data[31:24] = 8'h93;
        req         = 4'b1010;
        step();
        step();
        check_count++;
        if (gnt !== 4'b0010)
            $display("[TB] FAIL early_drop_owner: got gnt=%b want 0010", gnt);
        else pass_count++;
        req = 4'b1000;
        step();
        check_count++;
        if (obs !== {4'b1000, 4'h9, 4'h3, 1'b0})
            $display("[TB] FAIL early_drop_handoff: got gnt=%b hi=%h lo=%h blank=%b want gnt=1000 hi=9 lo=3 blank=0",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
    endtask

    task automatic test_release_idle();
        do_reset();
        data       = '0;
        data[15:8] = 8'h17;
        req        = 4'b0010;
        step();
        check_count++;
        if (obs !== {4'b0010, 4'h1, 4'h7, 1'b0})
            $display("[TB] FAIL release_idle_grant: got gnt=%b hi=%h lo=%h blank=%b want gnt=0010 hi=1 lo=7 blank=0",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
        req = 4'b0000;
        step();
        check_count++;
        if (obs !== {4'b0000, 4'hF, 4'hF, 1'b1})
            $display("[TB] FAIL release_idle_blank: got gnt=%b hi=%h lo=%h blank=%b want gnt=0000 hi=f lo=f blank=1",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
    endtask

    task automatic test_priority();
        do_reset();
        data        = '0;
        data[7:0]   = 8'h42;
        data[23:16] = 8'h56;
        req         = 4'b0100;
        step();
        check_count++;
        if (gnt !== 4'b0100)
            $display("[TB] FAIL prio_owner2: got gnt=%b want 0100", gnt);
        else pass_count++;
        req = 4'b0101;
`ifdef HEX_SCHED_PRIO_EN
        step();
        check_count++;
        if (obs !== {4'b0001, 4'h4, 4'h2, 1'b0})
            $display("[TB] FAIL prio_preempt: got gnt=%b hi=%h lo=%h want gnt=0001 hi=4 lo=2", gnt, digit_hi, digit_lo);
        else pass_count++;
`else
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (obs !== {4'b0100, 4'h5, 4'h6, 1'b0})
                $display("[TB] FAIL prio_wait[%0d]: got gnt=%b hi=%h lo=%h want gnt=0100 hi=5 lo=6", i, gnt, digit_hi, digit_lo);
            else pass_count++;
        end
        step();
        check_count++;
        if (obs !== {4'b0001, 4'h4, 4'h2, 1'b0})
            $display("[TB] FAIL prio_after_dwell: got gnt=%b hi=%h lo=%h want gnt=0001 hi=4 lo=2", gnt, digit_hi, digit_lo);
        else pass_count++;
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        data = 32'h93561742;
        req  = 4'b1111;
        step();
        step();
        check_count++;
        if (obs !== {4'b0001, 4'h4, 4'h2, 1'b0})
            $display("[TB] FAIL mid_reset_owner: got gnt=%b hi=%h lo=%h want gnt=0001 hi=4 lo=2", gnt, digit_hi, digit_lo);
        else pass_count++;
        reset = 1'b1;
        step();
        check_count++;
        if (obs !== {4'b0000, 4'hF, 4'hF, 1'b1})
            $display("[TB] FAIL mid_reset_blank: got gnt=%b hi=%h lo=%h blank=%b want gnt=0000 hi=f lo=f blank=1",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
        reset = 1'b0;
        step();
        check_count++;
        if (obs !== {4'b0001, 4'h4, 4'h2, 1'b0})
            $display("[TB] FAIL mid_reset_regrant: got gnt=%b hi=%h lo=%h blank=%b want gnt=0001 hi=4 lo=2 blank=0",
                     gnt, digit_hi, digit_lo, blank);
        else pass_count++;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        reset       = 1'b1;
        req         = '0;
        data        = '0;
        test_reset();
        test_single();
        test_live_digits();
        test_round_robin();
        test_early_drop();
        test_release_idle();
        test_priority();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
